uart_xcvr_param: RTL and testbench
==================================

Name: uart_xcvr_param

Overview:
Parametrised full-duplex UART transceiver for the RS232 subsystem. It replaces the fixed 8N1 transmit/receive pair with configurable data width, oversampling ratio, parity and stop bits. The receiver adds start-bit glitch rejection, parity-error reporting and framing-error reporting. It sits between the system-side byte interface and the serial pins. sys_clk runs at OVERSAMPLE x baud, so no separate baud tick is used.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
OVERSAMPLE, 16, sys_clk cycles per bit cell; must be even and >= 4.
PARITY_EN, 0, 1 adds a parity bit after the data bits.
PARITY_ODD, 0, 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits transmitted; 1 or 2.

Ports:
sys_clk  in  1  clock, OVERSAMPLE x baud
sys_rst_l  in  1  reset; asynchronous, active-low
xmitH  in  1  transmit request; sampled only while xmit_doneH=1
xmit_dataH  in  DATA_BITS  transmit word; captured when a request is accepted
uart_xmitH  out  1  serial TX line, registered
xmit_doneH  out  1  1 = transmitter idle and ready
uart_dataH  in  1  serial RX line, asynchronous to sys_clk
rec_dataH  out  DATA_BITS  last received word; held until the next frame
rec_validH  out  1  one-cycle pulse when rec_dataH updates
rec_parity_errH  out  1  parity error for the last frame; held
rec_frame_errH  out  1  stop bit sampled 0 for the last frame; held

Behaviour:
- Reset values (asynchronous): uart_xmitH=1, xmit_doneH=1, rec_dataH=0, rec_validH=0, both error flags 0.
- Reset values (internal): RX synchroniser flops=1, both FSMs in IDLE, all counters 0.
- Reset mid-frame aborts immediately; no partial data or flags are produced.

TX FSM (IDLE, START, DATA, PARITY, STOP):
- IDLE: uart_xmitH=1, xmit_doneH=1.
- Accept: xmitH=1 in IDLE captures xmit_dataH into the shift register. The next cycle, uart_xmitH=0 and xmit_doneH=0.
- START: line held 0 for OVERSAMPLE cycles.
- DATA: DATA_BITS cells, LSB first, each OVERSAMPLE cycles.
- PARITY (only if PARITY_EN=1): one cell carrying the XOR of the data bits, inverted when PARITY_ODD=1.
- STOP: STOP_BITS cells of 1.
- Frame length is (1+DATA_BITS+PARITY_EN+STOP_BITS) x OVERSAMPLE cycles from the first start cycle. xmit_doneH rises on the cycle after the last stop cycle.
- xmitH is ignored while busy. If xmitH is held high, back-to-back frames start with one IDLE cycle between them.
- Bit-cell counter is ceil(log2(OVERSAMPLE)) bits wide; bit counter is 4 bits wide. Both wrap only under FSM control.

RX path:
- uart_dataH passes through a 2-flop synchroniser initialised to 1; all RX decisions use the second flop.
- RX FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: a synchronised 0 enters START with the cell counter cleared.
- START: at count OVERSAMPLE/2-1 the line is re-sampled. If it is 1, treat as a glitch and return to IDLE with no outputs. If it is 0, the cell counter restarts.
- Subsequent samples are taken every OVERSAMPLE cycles, i.e. at mid-cell.
- DATA: bits are shifted in LSB first.
- PARITY (if enabled): the sampled bit is compared against the computed parity.
- STOP: only the first stop bit is sampled, whatever STOP_BITS is. On the stop-sample cycle +1:
  - rec_dataH is loaded;
  - rec_parity_errH and rec_frame_errH are updated (parity flag is 0 when PARITY_EN=0);
  - rec_validH pulses for exactly one cycle.
- After STOP: a stop sample of 1 returns to IDLE. A stop sample of 0 enters WAIT_HIGH, which waits for the line to read 1 before returning to IDLE, so breaks produce exactly one frame-error report.
- Flags and data change only on rec_validH cycles.
- TX and RX are fully independent; simultaneous activity is legal.

Test Plan:
1. Reset with DATA_BITS=8, OVERSAMPLE=16 -> uart_xmitH=1, xmit_doneH=1, rec_dataH=0x00, rec_validH=0, both flags 0.
2. TX 0xA5, no parity, 1 stop:
   - line is 0 for 16 cycles, then bits 1,0,1,0,0,1,0,1 for 16 cycles each, then 1 for 16 cycles;
   - xmit_doneH is low for 160 cycles;
   - xmitH pulsed mid-frame has no effect.
3. Loopback 0x3C with PARITY_EN=1, PARITY_ODD=0 -> transmitted parity bit is 0; rec_dataH=0x3C, one rec_validH pulse, parity_err=0, frame_err=0.
4. Inject an RX frame of 0x3C with the parity bit flipped to 1 -> rec_dataH=0x3C, rec_parity_errH=1; the next clean frame clears it to 0.
5. Drive a 4-cycle low glitch on uart_dataH -> no rec_validH, RX back in IDLE. A following valid 0x81 frame is received correctly.
6. Frame 0x55 with the stop bit driven 0, then the line held 0 for 3 cells -> exactly one rec_validH, rec_dataH=0x55, frame_err=1. A new frame is received only after the line returns high.
7. Assert sys_rst_l low during TX data bit 3 -> uart_xmitH=1 and xmit_doneH=1 asynchronously. The next xmitH sends a full, correct frame.

Source files
------------

// File: rtl/uart_xcvr_param.sv
// Parametrised full-duplex UART: independent TX and RX state machines, both
// timed directly from sys_clk running at OVERSAMPLE x baud.
module uart_xcvr_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_l,
  input  logic                 xmitH,
  input  logic [DATA_BITS-1:0] xmit_dataH,
  output logic                 uart_xmitH,
  output logic                 xmit_doneH,
  input  logic                 uart_dataH,
  output logic [DATA_BITS-1:0] rec_dataH,
  output logic                 rec_validH,
  output logic                 rec_parity_errH,
  output logic                 rec_frame_errH
);

  localparam int              CW        = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0]   CELL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit              PAR_ON    = (PARITY_EN != 0);
  localparam logic            PAR_INV   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  tx_state_t            r_tx_state;
  logic [CW-1:0]        r_tx_cell;
  logic [3:0]           r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;

  rx_state_t            r_rx_state;
  logic [CW-1:0]        r_rx_cell;
  logic [3:0]           r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par_err;
  logic                 r_rx_meta;
  logic                 r_rx_sync;

  // Transmitter. The line level for each cell is loaded on the edge that
  // enters the cell, so uart_xmitH is a plain flop output.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      r_tx_state <= TX_IDLE;
      r_tx_cell  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      uart_xmitH <= 1'b1;
      xmit_doneH <= 1'b1;
    end else begin
      // NOTE: every flop here uses <=, so all right-hand sides read pre-edge values.
      case (r_tx_state)
        TX_IDLE: begin
          if (xmitH) begin
            r_tx_shift <= xmit_dataH;
            r_tx_par   <= (^xmit_dataH) ^ PAR_INV;
            r_tx_cell  <= '0;
            r_tx_bit   <= '0;
            uart_xmitH <= 1'b0;
            xmit_doneH <= 1'b0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_cell == CELL_LAST) begin
            r_tx_cell  <= '0;
            uart_xmitH <= r_tx_shift[0];
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_cell <= r_tx_cell + 1'b1;
          end
        end
        TX_DATA: begin
          if (r_tx_cell == CELL_LAST) begin
            r_tx_cell <= '0;
            if (r_tx_bit == DATA_LAST) begin
              r_tx_bit <= '0;
              if (PAR_ON) begin
                uart_xmitH <= r_tx_par;
                r_tx_state <= TX_PARITY;
              end else begin
                uart_xmitH <= 1'b1;
                r_tx_state <= TX_STOP;
              end
            end else begin
              r_tx_bit   <= r_tx_bit + 1'b1;
              r_tx_shift <= r_tx_shift >> 1;
              uart_xmitH <= r_tx_shift[1];
            end
          end else begin
            r_tx_cell <= r_tx_cell + 1'b1;
          end
        end
        TX_PARITY: begin
          if (r_tx_cell == CELL_LAST) begin
            r_tx_cell  <= '0;
            uart_xmitH <= 1'b1;
            r_tx_state <= TX_STOP;
          end else begin
            r_tx_cell <= r_tx_cell + 1'b1;
          end
        end
        TX_STOP: begin
          if (r_tx_cell == CELL_LAST) begin
            r_tx_cell <= '0;
            if (r_tx_bit == STOP_LAST) begin
              r_tx_bit   <= '0;
              xmit_doneH <= 1'b1;
              r_tx_state <= TX_IDLE;
            end else begin
              r_tx_bit <= r_tx_bit + 1'b1;
            end
          end else begin
            r_tx_cell <= r_tx_cell + 1'b1;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // Receiver. Sampling is aligned to mid-cell by the half-cell START check;
  // after that every sample is one full cell apart.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      r_rx_meta       <= 1'b1;
      r_rx_sync       <= 1'b1;
      r_rx_state      <= RX_IDLE;
      r_rx_cell       <= '0;
      r_rx_bit        <= '0;
      r_rx_shift      <= '0;
      r_rx_par_err    <= 1'b0;
      rec_dataH       <= '0;
      rec_validH      <= 1'b0;
      rec_parity_errH <= 1'b0;
      rec_frame_errH  <= 1'b0;
    end else begin
      r_rx_meta  <= uart_dataH;
      r_rx_sync  <= r_rx_meta;
      rec_validH <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rx_sync) begin
            r_rx_cell  <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cell == HALF_LAST) begin
            r_rx_cell  <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cell <= r_rx_cell + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cell == CELL_LAST) begin
            r_rx_cell  <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_bit == DATA_LAST) begin
              r_rx_bit   <= '0;
              r_rx_state <= PAR_ON ? RX_PARITY : RX_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + 1'b1;
            end
          end else begin
            r_rx_cell <= r_rx_cell + 1'b1;
          end
        end
        RX_PARITY: begin
          if (r_rx_cell == CELL_LAST) begin
            r_rx_cell    <= '0;
            r_rx_par_err <= r_rx_sync ^ (^r_rx_shift) ^ PAR_INV;
            r_rx_state   <= RX_STOP;
          end else begin
            r_rx_cell <= r_rx_cell + 1'b1;
          end
        end
        RX_STOP: begin
          // Only the first stop bit is examined; a 0 parks in WAIT_HIGH so a
          // held break reports a single framing error.
          if (r_rx_cell == CELL_LAST) begin
            r_rx_cell       <= '0;
            rec_dataH       <= r_rx_shift;
            rec_validH      <= 1'b1;
            rec_parity_errH <= PAR_ON ? r_rx_par_err : 1'b0;
            rec_frame_errH  <= ~r_rx_sync;
            r_rx_state      <= r_rx_sync ? RX_IDLE : RX_WAIT_HIGH;
          end else begin
            r_rx_cell <= r_rx_cell + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (r_rx_sync) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_xcvr_param.sv
// Bench for uart_xcvr_param: instance A is 8N1, instance B is 8E2. Expected
// frames and receive results come from a bit-list model of the UART frame.
module tb_uart_xcvr_param;

  localparam int OS = 16;

  logic       sys_clk = 1'b0;
  logic       sys_rst_l;
  logic       a_xmit, b_xmit;
  logic [7:0] a_xdata, b_xdata;
  logic       a_tx, b_tx, a_done, b_done;
  logic       a_loop, b_loop, a_drv, b_drv;
  logic [7:0] a_rdata, b_rdata;
  logic       a_rvalid, b_rvalid, a_perr, b_perr, a_ferr, b_ferr;
  wire        a_rx = a_loop ? a_tx : a_drv;
  wire        b_rx = b_loop ? b_tx : b_drv;

  int n_pass  = 0;
  int n_total = 0;
  int vcnt_a  = 0;
  int vcnt_b  = 0;

  typedef logic bits_t [16];

  typedef struct {
    logic [7:0] data;
    bit         flip;
    bit         stop_zero;
    logic [7:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } rx_vec_t;

  always #5 sys_clk = ~sys_clk;

  uart_xcvr_param #(.DATA_BITS(8), .OVERSAMPLE(OS)) u_dut_a (
    .sys_clk(sys_clk), .sys_rst_l(sys_rst_l),
    .xmitH(a_xmit), .xmit_dataH(a_xdata), .uart_xmitH(a_tx), .xmit_doneH(a_done),
    .uart_dataH(a_rx), .rec_dataH(a_rdata), .rec_validH(a_rvalid),
    .rec_parity_errH(a_perr), .rec_frame_errH(a_ferr));

  uart_xcvr_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0),
                    .STOP_BITS(2)) u_dut_b (
    .sys_clk(sys_clk), .sys_rst_l(sys_rst_l),
    .xmitH(b_xmit), .xmit_dataH(b_xdata), .uart_xmitH(b_tx), .xmit_doneH(b_done),
    .uart_dataH(b_rx), .rec_dataH(b_rdata), .rec_validH(b_rvalid),
    .rec_parity_errH(b_perr), .rec_frame_errH(b_ferr));

  // Each sampled high cycle of rec_validH counts once, so a frame that
  // produces a wider pulse shows up as an extra count.
  always @(negedge sys_clk) begin
    if (a_rvalid === 1'b1) vcnt_a++;
    if (b_rvalid === 1'b1) vcnt_b++;
  end

  function automatic logic tx_of(input int i);    return i == 0 ? a_tx : b_tx;       endfunction
  function automatic logic done_of(input int i);  return i == 0 ? a_done : b_done;   endfunction
  function automatic logic loop_of(input int i);  return i == 0 ? a_loop : b_loop;   endfunction
  function automatic logic [7:0] rdata_of(input int i); return i == 0 ? a_rdata : b_rdata; endfunction
  function automatic logic perr_of(input int i);  return i == 0 ? a_perr : b_perr;   endfunction
  function automatic logic ferr_of(input int i);  return i == 0 ? a_ferr : b_ferr;   endfunction
  function automatic int   vcnt_of(input int i);  return i == 0 ? vcnt_a : vcnt_b;   endfunction

  task automatic set_xmit(input int i, input logic v, input logic [7:0] d);
    if (i == 0) begin a_xmit = v; a_xdata = d; end
    else        begin b_xmit = v; b_xdata = d; end
  endtask

  task automatic set_rx(input int i, input logic v);
    if (i == 0) a_drv = v; else b_drv = v;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Frame as a list of bit cells: start, data LSB first, optional even
  // parity (optionally corrupted), then the stop cells at level stopv.
  function automatic void model_frame(input int i, input logic [7:0] d, input bit flip,
                                      input logic stopv, output bits_t fb, output int n);
    int n_stop = (i == 0) ? 1 : 2;
    fb = '{default: 1'b1};
    fb[0] = 1'b0;
    for (int j = 0; j < 8; j++) fb[1 + j] = d[j];
    n = 9;
    if (i == 1) begin
      fb[n] = logic'($countones(d) % 2) ^ flip;
      n++;
    end
    for (int s = 0; s < n_stop; s++) begin
      fb[n] = stopv;
      n++;
    end
  endfunction

  task automatic wait_done(input int i);
    int t = 0;
    while (done_of(i) !== 1'b1 && t < 2000) begin
      @(negedge sys_clk);
      t++;
    end
    if (t >= 2000) begin
      n_total++;
      $display("FAIL done_timeout: xmit_doneH never rose on instance %0d", i);
    end
  endtask

  // Sends one word and follows the line cycle by cycle against the model.
  // poke pulses xmitH mid-frame; cap returns the mid-cell line levels.
  task automatic tx_frame(input int i, input logic [7:0] d, input bit poke, output bits_t cap);
    bits_t fb;
    int n, bad, low, v0;
    model_frame(i, d, 1'b0, 1'b1, fb, n);
    cap = '{default: 1'b1};
    wait_done(i);
    v0 = vcnt_of(i);
    set_xmit(i, 1'b1, d);
    @(negedge sys_clk);
    set_xmit(i, 1'b0, d);
    bad = 0;
    low = 0;
    for (int k = 0; k < n * OS; k++) begin
      if (k > 0) @(negedge sys_clk);
      if (tx_of(i) !== fb[k / OS]) bad++;
      if (done_of(i) === 1'b0) low++;
      if (k % OS == OS / 2) cap[k / OS] = tx_of(i);
      if (poke && k == 50) set_xmit(i, 1'b1, ~d);
      if (poke && k == 51) set_xmit(i, 1'b0, d);
    end
    @(negedge sys_clk);
    check("tx_wave_errors", bad, 0);
    check("tx_busy_cycles", low, n * OS);
    check("tx_done_after_frame", done_of(i), 1'b1);
    if (loop_of(i)) begin
      check("loop_valid_count", vcnt_of(i), v0 + 1);
      check("loop_rec_data", rdata_of(i), d);
      check("loop_flags", {perr_of(i), ferr_of(i)}, 2'b00);
    end
  endtask

  // Drives a frame onto an RX pin from the bench, then optional extra low
  // cells (a held break), then two idle cells.
  task automatic rx_frame(input int i, input logic [7:0] d, input bit flip,
                          input logic stopv, input int extra_low);
    bits_t fb;
    int n;
    model_frame(i, d, flip, stopv, fb, n);
    for (int b = 0; b < n; b++) begin
      set_rx(i, fb[b]);
      repeat (OS) @(negedge sys_clk);
    end
    set_rx(i, 1'b0);
    repeat (extra_low * OS) @(negedge sys_clk);
    set_rx(i, 1'b1);
    repeat (2 * OS) @(negedge sys_clk);
  endtask

  initial begin
    rx_vec_t vecs[6];
    bits_t   cap;
    int      v0, low;
    logic [7:0] d;

    vecs[0] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{8'hA7, 1'b0, 1'b1, 8'hA7, 1'b0, 1'b1};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1};
    vecs[5] = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0};

    sys_rst_l = 1'b0;
    a_xmit = 1'b0; b_xmit = 1'b0; a_xdata = '0; b_xdata = '0;
    a_drv = 1'b1;  b_drv = 1'b1;  a_loop = 1'b1; b_loop = 1'b1;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_uart_xmitH", a_tx, 1'b1);
    check("rst_xmit_doneH", a_done, 1'b1);
    check("rst_rec_dataH", a_rdata, 8'h00);
    check("rst_rec_validH", a_rvalid, 1'b0);
    check("rst_parity_err", a_perr, 1'b0);
    check("rst_frame_err", a_ferr, 1'b0);
    check("rst_b_tx_done", {b_tx, b_done}, 2'b11);
    sys_rst_l = 1'b1;
    repeat (2) @(negedge sys_clk);

    // 0xA5 on 8N1 with a stray mid-frame request, looped back to RX
    tx_frame(0, 8'hA5, 1'b1, cap);
    repeat (20) @(negedge sys_clk);
    check("tx_ignored_midframe_req", a_done, 1'b1);

    // xmitH held high: one idle cycle between frames
    v0 = vcnt_a;
    set_xmit(0, 1'b1, 8'h0F);
    @(negedge sys_clk);
    low = 0;
    while (a_done === 1'b0 && low < 1000) begin
      low++;
      @(negedge sys_clk);
    end
    check("b2b_first_busy", low, 10 * OS);
    check("b2b_idle_done", a_done, 1'b1);
    @(negedge sys_clk);
    check("b2b_restart", {a_done, a_tx}, 2'b00);
    set_xmit(0, 1'b0, 8'h0F);
    wait_done(0);
    check("b2b_rx_count", vcnt_a, v0 + 2);
    check("b2b_rx_data", a_rdata, 8'h0F);

    // Random words, 8N1 loopback
    for (int r = 0; r < 6; r++) begin
      d = 8'($urandom_range(0, 255));
      tx_frame(0, d, 1'b0, cap);
    end

    // 0x3C with even parity, 2 stops, loopback; parity cell must be 0
    tx_frame(1, 8'h3C, 1'b0, cap);
    check("tx_parity_bit_3C", cap[9], 1'b0);
    for (int r = 0; r < 3; r++) begin
      d = 8'($urandom_range(0, 255));
      tx_frame(1, d, 1'b0, cap);
    end

    // Injected parity/framing cases on the 8E2 receiver
    b_loop = 1'b0;
    repeat (OS) @(negedge sys_clk);
    for (int v = 0; v < 6; v++) begin
      v0 = vcnt_b;
      rx_frame(1, vecs[v].data, vecs[v].flip, ~vecs[v].stop_zero, vecs[v].stop_zero ? 2 : 0);
      check($sformatf("vec%0d_valid", v), vcnt_b, v0 + 1);
      check($sformatf("vec%0d_data", v), b_rdata, vecs[v].exp_data);
      check($sformatf("vec%0d_perr", v), b_perr, vecs[v].exp_perr);
      check($sformatf("vec%0d_ferr", v), b_ferr, vecs[v].exp_ferr);
    end

    // Start-bit glitch, then a clean 0x81
    a_loop = 1'b0;
    repeat (OS) @(negedge sys_clk);
    v0 = vcnt_a;
    set_rx(0, 1'b0);
    repeat (4) @(negedge sys_clk);
    set_rx(0, 1'b1);
    repeat (3 * OS) @(negedge sys_clk);
    check("glitch_no_valid", vcnt_a, v0);
    rx_frame(0, 8'h81, 1'b0, 1'b1, 0);
    check("after_glitch_valid", vcnt_a, v0 + 1);
    check("after_glitch_data", a_rdata, 8'h81);
    check("after_glitch_flags", {a_perr, a_ferr}, 2'b00);

    // Break: stop bit 0 and the line held low long enough that a receiver
    // re-arming without waiting for high would complete a second frame
    v0 = vcnt_a;
    rx_frame(0, 8'h55, 1'b0, 1'b0, 12);
    check("break_single_valid", vcnt_a, v0 + 1);
    check("break_data", a_rdata, 8'h55);
    check("break_frame_err", a_ferr, 1'b1);
    check("break_parity_err", a_perr, 1'b0);
    rx_frame(0, 8'h12, 1'b0, 1'b1, 0);
    check("post_break_valid", vcnt_a, v0 + 2);
    check("post_break_data", a_rdata, 8'h12);
    check("post_break_ferr", a_ferr, 1'b0);

    // Asynchronous reset during TX data bit 3, with RX looped mid-frame
    a_loop = 1'b1;
    wait_done(0);
    set_xmit(0, 1'b1, 8'hC3);
    @(negedge sys_clk);
    set_xmit(0, 1'b0, 8'hC3);
    repeat (4 * OS + 5) @(negedge sys_clk);
    #2 sys_rst_l = 1'b0;
    #1;
    check("async_rst_tx", a_tx, 1'b1);
    check("async_rst_done", a_done, 1'b1);
    check("async_rst_rdata", a_rdata, 8'h00);
    repeat (2) @(negedge sys_clk);
    sys_rst_l = 1'b1;
    v0 = vcnt_a;
    repeat (2 * OS) @(negedge sys_clk);
    check("rst_abort_no_valid", vcnt_a, v0);
    tx_frame(0, 8'hC3, 1'b0, cap);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
